gate_dispatcher: RTL
====================

Name: gate_dispatcher

Overview:
- Sits directly downstream of the netlist memory stage and upstream of the garbling core.
- Walks the stored gate list for each garbling clock cycle by driving rd_addr, and issues one gate per handshake to the core with its decoded fields and computed output wire id.
- Tells the netlist stage when to re-prepare for the next sequential cycle, and reports completion and gate statistics.

Parameters:
S, 14, wire/address width; matches netlist stage field width.
CC_W, 16, width of sequential-cycle count.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start  in  1  launch pulse; sampled in IDLE only.
num_cycles  in  CC_W  sequential cycles to garble; latched on start; 0 treated as 1.
nl_ready  in  1  netlist stage PREP pulse; fields valid from next cycle.
init_size, input_size, dff_size, gate_size  in  S  circuit parameters from netlist stage.
in0, in1  in  S  gate input wire ids for current rd_addr.
in0F, in1F  in  1  input is a circuit input.
g_logic  in  4  gate truth table.
is_output  in  1  gate output is a circuit output.
rd_addr  out  S  gate index presented to netlist stage.
prep_next_cycle  out  1  one-cycle request to netlist stage to re-enter PREP.
gate_valid  out  1  issue valid.
gate_ready  in  1  garbling core accepts.
gate_in0, gate_in1  out  S  issued input wire ids.
gate_in0F, gate_in1F, gate_is_output  out  1  issued flags.
gate_logic  out  4  issued truth table.
gate_free  out  1  1 when gate_logic is 4'b0110 or 4'b1001 (free XOR/XNOR).
gate_out_wire  out  S  init_size+input_size+dff_size+rd_addr, modulo 2^S.
cycle_idx  out  CC_W  current sequential cycle.
done  out  1  level, high in DONE.
free_cnt, nonfree_cnt  out  32  accepted gates by class, cumulative per run.

Behaviour:
- Reset (synchronous): state IDLE; rd_addr=0, cycle_idx=0, both counters 0. All outputs 0: gate_valid, prep_next_cycle, done, and all gate_* fields.
- gate_* fields are combinational copies of the netlist inputs, gated by gate_valid. When gate_valid=0, they are driven to 0.
- IDLE: on start, latch num_cycles (0→1) into cyc_total, clear counters and cycle_idx, go WAIT_NL.
- WAIT_NL: wait for nl_ready. On nl_ready, set rd_addr=0 and go ISSUE.
  - Fields are valid in ISSUE because the netlist stage provides same-cycle fields for rd_addr from the cycle after its ready pulse.
- ISSUE:
  - If gate_size<=0, go CYCLE_END with no gate_valid.
  - Otherwise gate_valid=1.
  - On gate_valid&&gate_ready, increment free_cnt or nonfree_cnt per gate_free.
  - If rd_addr==gate_size-1, go CYCLE_END; else rd_addr+1.
  - While gate_ready=0, rd_addr and all gate_* outputs hold stable. gate_valid never drops without acceptance.
- CYCLE_END (one cycle, gate_valid=0):
  - If cycle_idx==cyc_total-1, go DONE with no prep_next_cycle.
  - Else assert prep_next_cycle for exactly this cycle, increment cycle_idx, and go WAIT_NL.
- DONE: done=1; rd_addr holds last value. Terminal until rst; start ignored.
- start outside IDLE is ignored. nl_ready outside WAIT_NL is ignored.
- Throughput: one gate per cycle with gate_ready held high. Overhead per sequential cycle:
  - 1 cycle CYCLE_END;
  - 1 cycle for the netlist PREP;
  - 1 cycle WAIT_NL→ISSUE.
- Counters wrap at 2^32. gate_out_wire addition truncates to S bits.
- Reset mid-run: returns to IDLE next edge; any in-flight gate is discarded and counters are cleared.

Test Plan:
- gate_size=3, dff_size=0, init=2, input=2, num_cycles=1, gate_ready=1 → gate_valid high 3 consecutive cycles with rd_addr 0,1,2 and gate_out_wire 4,5,6; no prep_next_cycle; done=1 two cycles after last accept.
- Same circuit, gate_ready low for 4 cycles on rd_addr=1 → rd_addr and gate_in0/in1 stable for all 4 cycles; total accepts=3; no skipped or duplicate index.
- num_cycles=3, gate_size=2 → exactly 2 prep_next_cycle pulses, each one cycle wide; cycle_idx steps 0,1,2; 6 accepts total; done after third cycle.
- g_logic sequence 0110,0001,1001,0111 → free_cnt=2, nonfree_cnt=2; gate_free high on accepts 1 and 3.
- gate_size=0, num_cycles=2 → never gate_valid; one prep_next_cycle pulse; done asserted.
- rst asserted during ISSUE at rd_addr=5 → next cycle state IDLE, gate_valid=0, rd_addr=0, counters 0; new start with num_cycles=0 runs exactly one cycle.

Source files
------------

// File: rtl/gate_dispatcher.sv
// Gate dispatcher: walks the netlist stage's gate list once per sequential cycle and
// hands each gate, with its computed output wire id, to the garbling core over valid/ready.
module gate_dispatcher #(
    parameter int unsigned S    = 14,
    parameter int unsigned CC_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CC_W-1:0] num_cycles,
    input  logic            nl_ready,
    input  logic [S-1:0]    init_size,
    input  logic [S-1:0]    input_size,
    input  logic [S-1:0]    dff_size,
    input  logic [S-1:0]    gate_size,
    input  logic [S-1:0]    in0,
    input  logic [S-1:0]    in1,
    input  logic            in0F,
    input  logic            in1F,
    input  logic [3:0]      g_logic,
    input  logic            is_output,
    output logic [S-1:0]    rd_addr,
    output logic            prep_next_cycle,
    output logic            gate_valid,
    input  logic            gate_ready,
    output logic [S-1:0]    gate_in0,
    output logic [S-1:0]    gate_in1,
    output logic            gate_in0F,
    output logic            gate_in1F,
    output logic            gate_is_output,
    output logic [3:0]      gate_logic,
    output logic            gate_free,
    output logic [S-1:0]    gate_out_wire,
    output logic [CC_W-1:0] cycle_idx,
    output logic            done,
    output logic [31:0]     free_cnt,
    output logic [31:0]     nonfree_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_NL,
        ST_ISSUE,
        ST_CYCLE_END,
        ST_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [S-1:0]    rd_addr_q, rd_addr_d;
    logic [CC_W-1:0] cycle_idx_q, cycle_idx_d;
    logic [CC_W-1:0] cyc_total_q, cyc_total_d;
    logic [31:0]     free_cnt_q, free_cnt_d;
    logic [31:0]     nonfree_cnt_q, nonfree_cnt_d;

    logic            valid_c;
    logic            prep_c;
    logic            done_c;
    logic            free_c;
    logic [S-1:0]    out_wire_c;

    // Gate output wires follow circuit inputs and flip-flop outputs in the wire numbering.
    assign out_wire_c = init_size + input_size + dff_size + rd_addr_q;
    assign free_c     = (g_logic == 4'b0110) || (g_logic == 4'b1001);

    // Next-state, counters and state-decoded strobes
    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        cycle_idx_d   = cycle_idx_q;
        cyc_total_d   = cyc_total_q;
        free_cnt_d    = free_cnt_q;
        nonfree_cnt_d = nonfree_cnt_q;
        valid_c       = 1'b0;
        prep_c        = 1'b0;
        done_c        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cyc_total_d   = (num_cycles == '0) ? CC_W'(1) : num_cycles;
                    cycle_idx_d   = '0;
                    free_cnt_d    = '0;
                    nonfree_cnt_d = '0;
                    state_d       = ST_WAIT_NL;
                end
            end
            ST_WAIT_NL: begin
                if (nl_ready) begin
                    rd_addr_d = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (gate_size == '0) begin
                    state_d = ST_CYCLE_END;
                end else begin
                    valid_c = 1'b1;
                    if (gate_ready) begin
                        if (free_c) begin
                            free_cnt_d = free_cnt_q + 32'd1;
                        end else begin
                            nonfree_cnt_d = nonfree_cnt_q + 32'd1;
                        end
                        if (rd_addr_q == gate_size - S'(1)) begin
                            state_d = ST_CYCLE_END;
                        end else begin
                            rd_addr_d = rd_addr_q + S'(1);
                        end
                    end
                end
            end
            ST_CYCLE_END: begin
                if (cycle_idx_q == cyc_total_q - CC_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    prep_c      = 1'b1;
                    cycle_idx_d = cycle_idx_q + CC_W'(1);
                    state_d     = ST_WAIT_NL;
                end
            end
            ST_DONE: begin
                done_c = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rd_addr_q     <= '0;
            cycle_idx_q   <= '0;
            cyc_total_q   <= '0;
            free_cnt_q    <= '0;
            nonfree_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            cycle_idx_q   <= cycle_idx_d;
            cyc_total_q   <= cyc_total_d;
            free_cnt_q    <= free_cnt_d;
            nonfree_cnt_q <= nonfree_cnt_d;
        end
    end

    // Issued fields follow the netlist stage directly, forced to zero when nothing is offered.
    assign gate_valid      = valid_c;
    assign gate_in0        = valid_c ? in0        : '0;
    assign gate_in1        = valid_c ? in1        : '0;
    assign gate_in0F       = valid_c & in0F;
    assign gate_in1F       = valid_c & in1F;
    assign gate_is_output  = valid_c & is_output;
    assign gate_logic      = valid_c ? g_logic    : 4'b0000;
    assign gate_free       = valid_c & free_c;
    assign gate_out_wire   = valid_c ? out_wire_c : '0;

    assign rd_addr         = rd_addr_q;
    assign prep_next_cycle = prep_c;
    assign done            = done_c;
    assign cycle_idx       = cycle_idx_q;
    assign free_cnt        = free_cnt_q;
    assign nonfree_cnt     = nonfree_cnt_q;

endmodule
